// File: rtl/cnn_layer_accel_quad_pkg.sv
// Shared state encoding and config-word field map for the quad job controller.
package cnn_layer_accel_quad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_REQ,
    CONFIG,
    RUN,
    DONE
  } state_t;

  localparam int CFG_WORD0 = 0;
  localparam int CFG_WORD1 = 1;

  // Word 0 field offsets and widths
  localparam int W0_PFB_LSB          = 0;
  localparam int W0_PFB_W            = 10;
  localparam int W0_STRIDE_LSB       = 10;
  localparam int W0_STRIDE_W         = 7;
  localparam int W0_CONV_OUT_FMT_LSB = 17;
  localparam int W0_CONV_OUT_FMT_W   = 5;
  localparam int W0_PADDING_LSB      = 22;
  localparam int W0_PADDING_W        = 5;
  localparam int W0_UPSAMPLE_BIT     = 27;
  localparam int W0_NUM_KERNELS_LSB  = 28;
  localparam int W0_NUM_KERNELS_W    = 7;
  localparam int W0_ROWS_LSB         = 35;
  localparam int W0_ROWS_W           = 10;
  localparam int W0_COLS_LSB         = 45;
  localparam int W0_COLS_W           = 10;
  localparam int W0_PIX_SEQ_LSB      = 55;
  localparam int W0_PIX_SEQ_W        = 12;
  localparam int W0_MASTER_BIT       = 67;
  localparam int W0_CASCADE_BIT      = 68;
  localparam int W0_USED_BITS        = 69;

endpackage

// File: rtl/cnn_layer_accel_quad_cfg_regs.sv
// Unpacks config words 0 and 1 into the quad *_cfg registers.
// Registers hold until the next capture of the same word; only reset clears them.
module cnn_layer_accel_quad_cfg_regs
  import cnn_layer_accel_quad_pkg::*;
#(
  parameter int W = 10
) (
  input  logic                          clk_if,
  input  logic                          rst_n,
  input  logic                          cap_word0,
  input  logic                          cap_word1,
  input  logic [127:0]                  config_data,
  output logic [W0_PFB_W-1:0]           pfb_full_count_cfg,
  output logic [W0_STRIDE_W-1:0]        stride_cfg,
  output logic [W0_CONV_OUT_FMT_W-1:0]  conv_out_fmt_cfg,
  output logic [W0_PADDING_W-1:0]       padding_cfg,
  output logic                          upsample_cfg,
  output logic [W0_NUM_KERNELS_W-1:0]   num_kernels_cfg,
  output logic [W0_ROWS_W-1:0]          num_output_rows_cfg,
  output logic [W0_COLS_W-1:0]          num_output_cols_cfg,
  output logic [W0_PIX_SEQ_W-1:0]       pix_seq_data_full_count_cfg,
  output logic                          master_quad_cfg,
  output logic                          cascade_cfg,
  output logic [W-1:0]                  num_expd_input_cols_cfg,
  output logic [W-1:0]                  num_expd_input_rows_cfg,
  output logic [W-1:0]                  crpd_input_col_start_cfg,
  output logic [W-1:0]                  crpd_input_row_start_cfg,
  output logic [W-1:0]                  crpd_input_col_end_cfg,
  output logic [W-1:0]                  crpd_input_row_end_cfg
);

  // Upper payload bits carry no word-0 field; word 1 uses at most the low 6W bits.
  logic unused_data_bits;
  assign unused_data_bits = ^config_data[127:W0_USED_BITS];

  always_ff @(posedge clk_if or negedge rst_n) begin
    if (!rst_n) begin
      pfb_full_count_cfg          <= '0;
      stride_cfg                  <= '0;
      conv_out_fmt_cfg            <= '0;
      padding_cfg                 <= '0;
      upsample_cfg                <= 1'b0;
      num_kernels_cfg             <= '0;
      num_output_rows_cfg         <= '0;
      num_output_cols_cfg         <= '0;
      pix_seq_data_full_count_cfg <= '0;
      master_quad_cfg             <= 1'b0;
      cascade_cfg                 <= 1'b0;
    end else if (cap_word0) begin
      pfb_full_count_cfg          <= config_data[W0_PFB_LSB +: W0_PFB_W];
      stride_cfg                  <= config_data[W0_STRIDE_LSB +: W0_STRIDE_W];
      conv_out_fmt_cfg            <= config_data[W0_CONV_OUT_FMT_LSB +: W0_CONV_OUT_FMT_W];
      padding_cfg                 <= config_data[W0_PADDING_LSB +: W0_PADDING_W];
      upsample_cfg                <= config_data[W0_UPSAMPLE_BIT];
      num_kernels_cfg             <= config_data[W0_NUM_KERNELS_LSB +: W0_NUM_KERNELS_W];
      num_output_rows_cfg         <= config_data[W0_ROWS_LSB +: W0_ROWS_W];
      num_output_cols_cfg         <= config_data[W0_COLS_LSB +: W0_COLS_W];
      pix_seq_data_full_count_cfg <= config_data[W0_PIX_SEQ_LSB +: W0_PIX_SEQ_W];
      master_quad_cfg             <= config_data[W0_MASTER_BIT];
      cascade_cfg                 <= config_data[W0_CASCADE_BIT];
    end
  end

  always_ff @(posedge clk_if or negedge rst_n) begin
    if (!rst_n) begin
      num_expd_input_cols_cfg  <= '0;
      num_expd_input_rows_cfg  <= '0;
      crpd_input_col_start_cfg <= '0;
      crpd_input_row_start_cfg <= '0;
      crpd_input_col_end_cfg   <= '0;
      crpd_input_row_end_cfg   <= '0;
    end else if (cap_word1) begin
      num_expd_input_cols_cfg  <= config_data[0*W +: W];
      num_expd_input_rows_cfg  <= config_data[1*W +: W];
      crpd_input_col_start_cfg <= config_data[2*W +: W];
      crpd_input_row_start_cfg <= config_data[3*W +: W];
      crpd_input_col_end_cfg   <= config_data[4*W +: W];
      crpd_input_row_end_cfg   <= config_data[5*W +: W];
    end
  end

endmodule

// File: rtl/cnn_layer_accel_quad_job_ctrl.sv
// Quad-side job/config responder: accepts a job, gathers config words 0/1,
// launches the core run and hands completion back to the host.
module cnn_layer_accel_quad_job_ctrl
  import cnn_layer_accel_quad_pkg::*;
#(
  parameter  int C_ROW_BUF_BRAM_DEPTH      = 1024,
  localparam int C_CLG2_ROW_BUF_BRAM_DEPTH = $clog2(C_ROW_BUF_BRAM_DEPTH)
) (
  input  logic                                 clk_if,
  input  logic                                 rst_n,
  input  logic                                 job_start,
  output logic                                 job_accept,
  input  logic [127:0]                         job_parameters,
  output logic                                 job_fetch_request,
  input  logic                                 job_fetch_ack,
  input  logic                                 job_fetch_complete,
  output logic                                 job_complete,
  input  logic                                 job_complete_ack,
  input  logic [3:0]                           config_valid,
  output logic [3:0]                           config_accept,
  input  logic [127:0]                         config_data,
  output logic [127:0]                         job_params_q,
  output logic                                 run_start,
  input  logic                                 run_done,
  output logic                                 cfg_err,
  output logic [9:0]                           pfb_full_count_cfg,
  output logic [6:0]                           stride_cfg,
  output logic [4:0]                           conv_out_fmt_cfg,
  output logic [4:0]                           padding_cfg,
  output logic                                 upsample_cfg,
  output logic [6:0]                           num_kernels_cfg,
  output logic [9:0]                           num_output_rows_cfg,
  output logic [9:0]                           num_output_cols_cfg,
  output logic [11:0]                          pix_seq_data_full_count_cfg,
  output logic                                 master_quad_cfg,
  output logic                                 cascade_cfg,
  output logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] num_expd_input_cols_cfg,
  output logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] num_expd_input_rows_cfg,
  output logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] crpd_input_col_start_cfg,
  output logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] crpd_input_row_start_cfg,
  output logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] crpd_input_col_end_cfg,
  output logic [C_CLG2_ROW_BUF_BRAM_DEPTH-1:0] crpd_input_row_end_cfg
);

  state_t state_q, state_d;
  logic   got_word0_q, got_word1_q, fetch_done_q;
  logic   job_accept_q, run_start_q, cfg_err_q;
  logic   in_config, cap_word0, cap_word1;
  logic   have_word0, have_word1, fetch_done_seen, cfg_ready;
  logic   job_take, err_event;

  // "have"/"seen" fold in this cycle's events so the exit can coincide with the last word.
  always_comb begin
    in_config       = (state_q == CONFIG);
    cap_word0       = in_config && config_valid[CFG_WORD0];
    cap_word1       = in_config && config_valid[CFG_WORD1];
    have_word0      = got_word0_q || cap_word0;
    have_word1      = got_word1_q || cap_word1;
    fetch_done_seen = fetch_done_q || (in_config && job_fetch_complete);
    cfg_ready       = have_word0 && have_word1 && fetch_done_seen;
    job_take        = (state_q == IDLE) && job_start;
    err_event       = (in_config && job_fetch_complete && !(have_word0 && have_word1))
                   || (!in_config && (|config_valid))
                   || ((state_q != RUN) && run_done);
  end

  always_comb begin
    state_d           = state_q;
    job_fetch_request = 1'b0;
    job_complete      = 1'b0;
    config_accept     = 4'b0000;
    case (state_q)
      IDLE:      if (job_start) state_d = FETCH_REQ;
      FETCH_REQ: begin
        job_fetch_request = 1'b1;
        if (job_fetch_ack) state_d = CONFIG;
      end
      CONFIG: begin
        config_accept = config_valid;
        if (cfg_ready) state_d = RUN;
      end
      RUN:       if (run_done) state_d = DONE;
      DONE: begin
        job_complete = 1'b1;
        if (job_complete_ack) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_if or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      job_accept_q <= 1'b0;
      run_start_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
      job_params_q <= '0;
      got_word0_q  <= 1'b0;
      got_word1_q  <= 1'b0;
      fetch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      job_accept_q <= job_take;
      run_start_q  <= in_config && cfg_ready;
      if (job_take) begin
        job_params_q <= job_parameters;
        got_word0_q  <= 1'b0;
        got_word1_q  <= 1'b0;
        fetch_done_q <= 1'b0;
      end else if (in_config) begin
        got_word0_q  <= have_word0;
        got_word1_q  <= have_word1;
        fetch_done_q <= fetch_done_seen;
      end
      // A new job wipes the previous job's error record.
      if (job_take)
        cfg_err_q <= 1'b0;
      else if (err_event)
        cfg_err_q <= 1'b1;
    end
  end

  assign job_accept = job_accept_q;
  assign run_start  = run_start_q;
  assign cfg_err    = cfg_err_q;

  cnn_layer_accel_quad_cfg_regs #(
    .W (C_CLG2_ROW_BUF_BRAM_DEPTH)
  ) u_cfg_regs (
    .clk_if                      (clk_if),
    .rst_n                       (rst_n),
    .cap_word0                   (cap_word0),
    .cap_word1                   (cap_word1),
    .config_data                 (config_data),
    .pfb_full_count_cfg          (pfb_full_count_cfg),
    .stride_cfg                  (stride_cfg),
    .conv_out_fmt_cfg            (conv_out_fmt_cfg),
    .padding_cfg                 (padding_cfg),
    .upsample_cfg                (upsample_cfg),
    .num_kernels_cfg             (num_kernels_cfg),
    .num_output_rows_cfg         (num_output_rows_cfg),
    .num_output_cols_cfg         (num_output_cols_cfg),
    .pix_seq_data_full_count_cfg (pix_seq_data_full_count_cfg),
    .master_quad_cfg             (master_quad_cfg),
    .cascade_cfg                 (cascade_cfg),
    .num_expd_input_cols_cfg     (num_expd_input_cols_cfg),
    .num_expd_input_rows_cfg     (num_expd_input_rows_cfg),
    .crpd_input_col_start_cfg    (crpd_input_col_start_cfg),
    .crpd_input_row_start_cfg    (crpd_input_row_start_cfg),
    .crpd_input_col_end_cfg      (crpd_input_col_end_cfg),
    .crpd_input_row_end_cfg      (crpd_input_row_end_cfg)
  );

endmodule

// File: tb/tb_cnn_layer_accel_quad_job_ctrl.sv
// Randomized scoreboard bench for the quad job controller: the driver queues
// expected accepts/runs, a negedge monitor pops them when the DUT pulses.
module tb_cnn_layer_accel_quad_job_ctrl;

  localparam int W = 10;

  logic          clk_if = 1'b0;
  logic          rst_n = 1'b1;
  logic          job_start = 1'b0, job_fetch_ack = 1'b0, job_fetch_complete = 1'b0;
  logic          job_complete_ack = 1'b0, run_done = 1'b0;
  logic [127:0]  job_parameters = '0, config_data = '0;
  logic [3:0]    config_valid = '0;
  logic          job_accept, job_fetch_request, job_complete, run_start, cfg_err;
  logic [3:0]    config_accept;
  logic [127:0]  job_params_q;
  logic [9:0]    pfb_full_count_cfg, num_output_rows_cfg, num_output_cols_cfg;
  logic [6:0]    stride_cfg, num_kernels_cfg;
  logic [4:0]    conv_out_fmt_cfg, padding_cfg;
  logic [11:0]   pix_seq_data_full_count_cfg;
  logic          upsample_cfg, master_quad_cfg, cascade_cfg;
  logic [W-1:0]  expd_cols, expd_rows, col_start, row_start, col_end, row_end;

  cnn_layer_accel_quad_job_ctrl dut (
    .clk_if(clk_if), .rst_n(rst_n),
    .job_start(job_start), .job_accept(job_accept), .job_parameters(job_parameters),
    .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
    .job_fetch_complete(job_fetch_complete), .job_complete(job_complete),
    .job_complete_ack(job_complete_ack), .config_valid(config_valid),
    .config_accept(config_accept), .config_data(config_data), .job_params_q(job_params_q),
    .run_start(run_start), .run_done(run_done), .cfg_err(cfg_err),
    .pfb_full_count_cfg(pfb_full_count_cfg), .stride_cfg(stride_cfg),
    .conv_out_fmt_cfg(conv_out_fmt_cfg), .padding_cfg(padding_cfg),
    .upsample_cfg(upsample_cfg), .num_kernels_cfg(num_kernels_cfg),
    .num_output_rows_cfg(num_output_rows_cfg), .num_output_cols_cfg(num_output_cols_cfg),
    .pix_seq_data_full_count_cfg(pix_seq_data_full_count_cfg),
    .master_quad_cfg(master_quad_cfg), .cascade_cfg(cascade_cfg),
    .num_expd_input_cols_cfg(expd_cols), .num_expd_input_rows_cfg(expd_rows),
    .crpd_input_col_start_cfg(col_start), .crpd_input_row_start_cfg(row_start),
    .crpd_input_col_end_cfg(col_end), .crpd_input_row_end_cfg(row_end)
  );

  always #5 clk_if = ~clk_if;

  int unsigned cyc = 0;
  always @(posedge clk_if) cyc <= cyc + 1;

  typedef struct {
    logic [127:0]       params;
    logic               err;
    logic [9:0]         pfb, rows, cols;
    logic [6:0]         stride, nk;
    logic [4:0]         fmt, pad;
    logic [11:0]        pix;
    logic               ups, master, cascade;
    logic [5:0][W-1:0]  w1f;
  } exp_run_t;

  exp_run_t     run_q[$];
  int unsigned  acc_q[$];
  int           n_cmp = 0, n_bad = 0;
  bit           pre_started = 0;
  logic [127:0] next_params = '0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] field(input logic [127:0] d, input int lsb, input int w);
    return (d >> lsb) & ((128'd1 << w) - 128'd1);
  endfunction

  function automatic logic [127:0] place(input logic [127:0] d, input int lsb, input int w,
                                         input logic [127:0] v);
    logic [127:0] m;
    m = ((128'd1 << w) - 128'd1) << lsb;
    return (d & ~m) | ((v << lsb) & m);
  endfunction

  // Reference model: expected cfg values read straight from the field tables.
  function automatic exp_run_t model(input logic [127:0] w0, input logic [127:0] w1,
                                     input logic [127:0] params, input logic err);
    exp_run_t e;
    e.params  = params;
    e.err     = err;
    e.pfb     = 10'(field(w0, 0, 10));
    e.stride  = 7'(field(w0, 10, 7));
    e.fmt     = 5'(field(w0, 17, 5));
    e.pad     = 5'(field(w0, 22, 5));
    e.ups     = 1'(field(w0, 27, 1));
    e.nk      = 7'(field(w0, 28, 7));
    e.rows    = 10'(field(w0, 35, 10));
    e.cols    = 10'(field(w0, 45, 10));
    e.pix     = 12'(field(w0, 55, 12));
    e.master  = 1'(field(w0, 67, 1));
    e.cascade = 1'(field(w0, 68, 1));
    for (int k = 0; k < 6; k++) e.w1f[k] = W'(field(w1, k * W, W));
    return e;
  endfunction

  // Monitor: pops expectations only when the DUT pulses job_accept / run_start.
  bit prev_rs = 0;
  always @(negedge clk_if) begin : monitor
    exp_run_t    e;
    int unsigned ec;
    if (rst_n) begin
      if (job_accept) begin
        if (acc_q.size() == 0) checkOutput("unexpected job_accept", 128'(1), 128'(0));
        else begin
          ec = acc_q.pop_front();
          checkOutput("job_accept cycle", 128'(cyc), 128'(ec));
          checkOutput("cfg_err at job_accept", 128'(cfg_err), 128'(0));
        end
      end
      if (run_start) begin
        checkOutput("run_start pulse width", 128'(prev_rs), 128'(0));
        if (run_q.size() == 0) checkOutput("unexpected run_start", 128'(1), 128'(0));
        else begin
          e = run_q.pop_front();
          checkOutput("job_params_q", job_params_q, e.params);
          checkOutput("cfg_err at run_start", 128'(cfg_err), 128'(e.err));
          checkOutput("pfb_full_count_cfg", 128'(pfb_full_count_cfg), 128'(e.pfb));
          checkOutput("stride_cfg", 128'(stride_cfg), 128'(e.stride));
          checkOutput("conv_out_fmt_cfg", 128'(conv_out_fmt_cfg), 128'(e.fmt));
          checkOutput("padding_cfg", 128'(padding_cfg), 128'(e.pad));
          checkOutput("upsample_cfg", 128'(upsample_cfg), 128'(e.ups));
          checkOutput("num_kernels_cfg", 128'(num_kernels_cfg), 128'(e.nk));
          checkOutput("num_output_rows_cfg", 128'(num_output_rows_cfg), 128'(e.rows));
          checkOutput("num_output_cols_cfg", 128'(num_output_cols_cfg), 128'(e.cols));
          checkOutput("pix_seq_cfg", 128'(pix_seq_data_full_count_cfg), 128'(e.pix));
          checkOutput("master_quad_cfg", 128'(master_quad_cfg), 128'(e.master));
          checkOutput("cascade_cfg", 128'(cascade_cfg), 128'(e.cascade));
          checkOutput("num_expd_input_cols_cfg", 128'(expd_cols), 128'(e.w1f[0]));
          checkOutput("num_expd_input_rows_cfg", 128'(expd_rows), 128'(e.w1f[1]));
          checkOutput("crpd_input_col_start_cfg", 128'(col_start), 128'(e.w1f[2]));
          checkOutput("crpd_input_row_start_cfg", 128'(row_start), 128'(e.w1f[3]));
          checkOutput("crpd_input_col_end_cfg", 128'(col_end), 128'(e.w1f[4]));
          checkOutput("crpd_input_row_end_cfg", 128'(row_end), 128'(e.w1f[5]));
        end
      end
      prev_rs = run_start;
    end else begin
      prev_rs = 0;
    end
  end

  task automatic tick();
    @(posedge clk_if);
    #1;
  endtask

  task automatic cfgCycle(input logic [3:0] v, input logic [127:0] d, input logic fc);
    config_valid = v;
    config_data = d;
    job_fetch_complete = fc;
    #1 checkOutput("config_accept", 128'(config_accept), 128'(v));
    tick();
    config_valid = '0;
    job_fetch_complete = 1'b0;
  endtask

  task automatic resetCheck();
    job_start = 0; job_fetch_ack = 0; job_fetch_complete = 0;
    job_complete_ack = 0; run_done = 0;
    config_valid = 4'b0011;
    rst_n = 1'b0;
    #1;
    checkOutput("reset job_accept", 128'(job_accept), 128'(0));
    checkOutput("reset job_fetch_request", 128'(job_fetch_request), 128'(0));
    checkOutput("reset job_complete", 128'(job_complete), 128'(0));
    checkOutput("reset config_accept", 128'(config_accept), 128'(0));
    checkOutput("reset run_start", 128'(run_start), 128'(0));
    checkOutput("reset cfg_err", 128'(cfg_err), 128'(0));
    checkOutput("reset job_params_q", job_params_q, 128'(0));
    checkOutput("reset word0 cfg", 128'({pfb_full_count_cfg, stride_cfg, conv_out_fmt_cfg,
                padding_cfg, upsample_cfg, num_kernels_cfg, num_output_rows_cfg,
                num_output_cols_cfg, pix_seq_data_full_count_cfg, master_quad_cfg,
                cascade_cfg}), 128'(0));
    checkOutput("reset word1 cfg", 128'({expd_cols, expd_rows, col_start, row_start,
                col_end, row_end}), 128'(0));
    config_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One complete job; flags choose how the config phase and handshakes are exercised.
  task automatic applyStimulus(input bit combined, input bit early, input bit stray_v,
                               input bit stray_d, input bit busy, input bit nominal);
    logic [127:0] w0, w1, params;
    exp_run_t     e;
    bit           w1_first, fc_with_last;
    int           run_wait;
    w0 = rand128();
    w1 = rand128();
    if (nominal) begin
      w0 = place(w0, 10, 7, 1);
      w0 = place(w0, 28, 7, 16);
      w0 = place(w0, 35, 10, 32);
      w0 = place(w0, 45, 10, 32);
      w0 = place(w0, 67, 1, 1);
      w1 = place(w1, 4 * W, W, 33);
    end
    if (combined) w1 = w0;
    if (!pre_started) begin
      params = rand128();
      job_parameters = params;
      job_start = 1'b1;
      acc_q.push_back(cyc + 1);
      tick();
    end else begin
      params = next_params;
    end
    job_start = 1'b0;
    pre_started = 0;
    checkOutput("job_fetch_request raised", 128'(job_fetch_request), 128'(1));
    if (stray_v) begin
      config_valid = 4'b1000;
      #1 checkOutput("config_accept outside CONFIG", 128'(config_accept), 128'(0));
      tick();
      config_valid = '0;
    end
    if (stray_d) begin
      run_done = 1'b1;
      tick();
      run_done = 1'b0;
    end
    repeat (nominal ? 3 : $urandom_range(0, 3)) tick();
    checkOutput("job_fetch_request held", 128'(job_fetch_request), 128'(1));
    job_fetch_ack = 1'b1;
    tick();
    job_fetch_ack = 1'b0;
    checkOutput("job_fetch_request cleared", 128'(job_fetch_request), 128'(0));

    e = model(w0, w1, params, early | stray_v | stray_d);
    if (combined) begin
      run_q.push_back(e);
      cfgCycle(4'b0011, w0, 1'b1);
    end else if (early) begin
      cfgCycle(4'b0001, w0, 1'b0);
      cfgCycle(4'b0000, rand128(), 1'b1);
      checkOutput("cfg_err after early fetch_complete", 128'(cfg_err), 128'(1));
      repeat (5) begin
        checkOutput("run_start while word missing", 128'(run_start), 128'(0));
        cfgCycle(4'b0100, 128'hFFFF, 1'b0);
      end
      run_q.push_back(e);
      cfgCycle(4'b0010, w1, 1'b0);
    end else begin
      w1_first = nominal ? 1'b0 : 1'($urandom_range(0, 1));
      fc_with_last = nominal ? 1'b0 : 1'($urandom_range(0, 1));
      if (!nominal && $urandom_range(0, 1) == 1) cfgCycle(4'b0001, rand128(), 1'b0);
      if (w1_first) cfgCycle(4'b0010, w1, 1'b0);
      else          cfgCycle(4'b0001, w0, 1'b0);
      cfgCycle(4'b0100, 128'hFFFF, 1'b0);
      run_q.push_back(e);
      if (w1_first) cfgCycle(4'b0001, w0, fc_with_last);
      else          cfgCycle(4'b0010, w1, fc_with_last);
      if (!fc_with_last) cfgCycle(4'b0000, rand128(), 1'b1);
    end
    checkOutput("run_start on RUN entry", 128'(run_start), 128'(1));
    if (nominal) begin
      checkOutput("nominal stride", 128'(stride_cfg), 128'(1));
      checkOutput("nominal num_kernels", 128'(num_kernels_cfg), 128'(16));
      checkOutput("nominal rows", 128'(num_output_rows_cfg), 128'(32));
      checkOutput("nominal cols", 128'(num_output_cols_cfg), 128'(32));
      checkOutput("nominal master", 128'(master_quad_cfg), 128'(1));
      checkOutput("nominal crpd_col_end", 128'(col_end), 128'(33));
    end

    run_wait = nominal ? 10 : $urandom_range(0, 12);
    if (busy) begin
      next_params = rand128();
      job_parameters = next_params;
      job_start = 1'b1;
    end
    repeat (run_wait) tick();
    checkOutput("job_complete before run_done", 128'(job_complete), 128'(0));
    run_done = 1'b1;
    tick();
    run_done = 1'b0;
    repeat ($urandom_range(1, 4)) begin
      checkOutput("job_complete held", 128'(job_complete), 128'(1));
      tick();
    end
    job_complete_ack = 1'b1;
    if (busy) acc_q.push_back(cyc + 2);
    tick();
    job_complete_ack = 1'b0;
    checkOutput("job_complete cleared", 128'(job_complete), 128'(0));
    if (busy) begin
      tick();
      pre_started = 1;
    end
  endtask

  task automatic abortJob();
    job_parameters = rand128();
    job_start = 1'b1;
    acc_q.push_back(cyc + 1);
    tick();
    job_start = 1'b0;
    job_fetch_ack = 1'b1;
    tick();
    job_fetch_ack = 1'b0;
    cfgCycle(4'b0001, rand128(), 1'b0);
    cfgCycle(4'b0000, rand128(), 1'b1);
    checkOutput("cfg_err before reset", 128'(cfg_err), 128'(1));
    resetCheck();
  endtask

  initial begin
    #2;
    resetCheck();
    applyStimulus(0, 0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    abortJob();
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    for (int j = 0; j < 24; j++) begin
      bit c, ea, sv, sd, b;
      c  = 1'($urandom_range(0, 1));
      ea = !c && ($urandom_range(0, 2) == 0);
      sv = ($urandom_range(0, 4) == 0);
      sd = !sv && ($urandom_range(0, 4) == 0);
      b  = (j < 23) && ($urandom_range(0, 2) == 0);
      applyStimulus(c, ea, sv, sd, b, 0);
    end
    tick();
    tick();
    checkOutput("accept queue drained", 128'(acc_q.size()), 128'(0));
    checkOutput("run queue drained", 128'(run_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/cnn_layer_accel_quad_job_ctrl.md
Name: cnn_layer_accel_quad_job_ctrl

Overview:
- Quad-side responder for the job/config protocol driven by the host/testbench interface.
- Accepts a job, requests and captures configuration words, and registers all quad *_cfg fields for the datapath.
- Launches the core run, then reports job completion.
- Sits between the host interface and the quad datapath.
- Single clock domain: clk_if.

Parameters:
- C_ROW_BUF_BRAM_DEPTH, 1024: row-buffer depth; sets the cropped/expanded field width.
- C_CLG2_ROW_BUF_BRAM_DEPTH, clog2(C_ROW_BUF_BRAM_DEPTH): width W of the six row-buffer cfg fields. Derived; not overridden.

Ports:
- clk_if  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- job_start  in  1  host requests a new job
- job_accept  out  1  one-cycle pulse: job taken
- job_parameters  in  128  job descriptor, sampled on acceptance
- job_fetch_request  out  1  level: request config fetch
- job_fetch_ack  in  1  host acknowledges fetch request
- job_fetch_complete  in  1  host has sent all config words
- job_complete  out  1  level: job finished
- job_complete_ack  in  1  host acknowledges completion
- config_valid  in  4  config_valid[k]: config_data carries word k
- config_accept  out  4  per-word accept, combinational
- config_data  in  128  config payload
- job_params_q  out  128  latched job_parameters
- run_start  out  1  one-cycle pulse to core
- run_done  in  1  core finished, pulse or level
- cfg_err  out  1  sticky: protocol violation this job
- pfb_full_count_cfg  out  10
- stride_cfg  out  7
- conv_out_fmt_cfg  out  5
- padding_cfg  out  5
- upsample_cfg  out  1
- num_kernels_cfg  out  7
- num_output_rows_cfg  out  10
- num_output_cols_cfg  out  10
- pix_seq_data_full_count_cfg  out  12
- master_quad_cfg  out  1
- cascade_cfg  out  1
- num_expd_input_cols_cfg, num_expd_input_rows_cfg, crpd_input_col_start_cfg, crpd_input_row_start_cfg, crpd_input_col_end_cfg, crpd_input_row_end_cfg  out  W each

Behaviour:
- Reset, asynchronous and active-low:
  - All outputs and cfg registers go to 0.
  - State goes to IDLE; word-received flags and the fetch-complete latch clear.
  - A reset mid-job abandons the job with no completion handshake.
- Config word 0 field map:
  - pfb[9:0], stride[16:10], conv_out_fmt[21:17], padding[26:22], upsample[27]
  - num_kernels[34:28], rows[44:35], cols[54:45], pix_seq[66:55]
  - master[67], cascade[68]; remaining bits ignored.
- Config word 1 field map (W-bit slices, in this order from bit 0):
  - expd_cols, expd_rows, crpd_col_start, crpd_row_start, crpd_col_end, crpd_row_end
  - Bits above 6W are ignored.
- Config words 2 and 3 are reserved: accepted and discarded.
- FSM states and transitions:
  - IDLE: job_start=1 -> register job_parameters into job_params_q, pulse job_accept next cycle, go to FETCH_REQ. Latency from job_start to job_accept is one cycle.
  - FETCH_REQ: job_fetch_request=1 until job_fetch_ack sampled high, then go to CONFIG. Clear request the same cycle ack is seen.
  - CONFIG:
    - config_accept = config_valid, so every set bit is accepted.
    - On valid&accept, word 0 and/or word 1 are captured in that cycle; multiple words in one cycle are allowed.
    - A repeated word overwrites the earlier capture.
    - job_fetch_complete is latched sticky.
    - Exit to RUN when both words have been captured and the latch is set. The condition may complete in the same cycle as the final word.
  - RUN: pulse run_start for one cycle on entry; wait for run_done, then go to DONE.
  - DONE: job_complete=1 until job_complete_ack is sampled high, then go to IDLE.
- config_accept=0 outside CONFIG.
- job_start outside IDLE is ignored: no job_accept. If job_start is still high on return to IDLE, it starts a new job.
- cfg_err is set when:
  - job_fetch_complete is seen in CONFIG with a word missing (the FSM keeps waiting);
  - any config_valid bit is set outside CONFIG;
  - run_done is seen outside RUN.
- cfg_err clears on the next job_accept.
- cfg outputs hold their values from capture until overwritten by the next job's config; they are not cleared in IDLE.

Decomposition:
- Package cnn_layer_accel_quad_pkg holds:
  - state enum {IDLE, FETCH_REQ, CONFIG, RUN, DONE};
  - the word-0 bit-offset localparams;
  - CFG_WORD0/CFG_WORD1 indices.
- Sub-module cnn_layer_accel_quad_cfg_regs holds the word-0/word-1 field unpack and registers. The FSM stays in the top level.

Test Plan:
- Nominal job:
  - Stimulus: job_start; ack after 3 cycles; word0 with stride=1, num_kernels=16, rows=cols=32, master=1; word1 with crpd_col_end=33; fetch_complete; run_done 10 cycles after run_start; complete_ack.
  - Response: job_accept exactly one cycle after job_start; cfg outputs match the fields; run_start single pulse; job_complete held until ack; state returns to IDLE.
- Combined capture:
  - Stimulus: config_valid=4'b0011 together with job_fetch_complete in a single cycle.
  - Response: both words captured; config_accept=4'b0011; RUN entered on the next cycle.
- Early fetch_complete:
  - Stimulus: fetch_complete arrives with only word 0 received; word 1 follows 5 cycles later.
  - Response: cfg_err=1; FSM stays in CONFIG; RUN is entered after word 1.
- Busy job_start:
  - Stimulus: job_start held high during RUN.
  - Response: no job_accept until after complete_ack; then a new job_accept with cfg_err cleared.
- Reset mid-job:
  - Stimulus: rst_n low in CONFIG.
  - Response: all outputs 0 immediately (asynchronous); after release, a fresh job runs normally.
- Reserved word:
  - Stimulus: config_valid=4'b0100 with data 0xFFFF.
  - Response: accepted; no cfg output changes.
